// File: rtl/ps2_receiver_pkg.sv
// Shared constants for the PS/2 receiver: frame geometry, break prefix,
// FSM state encodings and the odd-parity check.
package ps2_receiver_pkg;

    localparam int         PS2_FRAME_LEN = 11;
    localparam logic [7:0] BREAK_PREFIX  = 8'hF0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // True when the data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Byte-wide synchronous FIFO; a push while full is dropped unless a pop
// frees a slot in the same cycle.
module ps2_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: pin synchronizer, clock de-glitch filter, frame FSM
// with timeout, and a paced output stage fed from a small scan-code FIFO.
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       KCLK,
    input  logic       RST,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] KCODE,
    output logic       KCOME,
    output logic       FRAME_ERR,
    output logic       OVERFLOW
);

    localparam int             FCW       = $clog2(FILTER_LEN + 1);
    localparam int             TCW       = $clog2(TIMEOUT);
    localparam int             DATA_BITS = PS2_FRAME_LEN - 3;
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);

    logic           clk_meta, clk_sync, data_meta, data_sync;
    logic           clk_filt;
    logic [FCW-1:0] filt_cnt;
    logic           fall;
    logic [1:0]     state;
    logic [3:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           parity_bit;
    logic [TCW-1:0] timeout_cnt;
    logic           timed_out;
    logic           push_good;
    logic           fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic           pop_req;

    always_ff @(posedge KCLK) begin
        if (RST) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= PS2_CLK;
            clk_sync  <= clk_meta;
            data_meta <= PS2_DATA;
            data_sync <= data_meta;
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive opposing sample.
    always_ff @(posedge KCLK) begin
        if (RST) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign fall      = clk_filt && !clk_sync && (filt_cnt == FILT_LAST);
    assign timed_out = (state != ST_IDLE) && !fall && (timeout_cnt == TO_LAST);
    assign push_good = fall && (state == ST_STOP) && data_sync
                       && odd_parity_ok(shift_reg, parity_bit);

    always_ff @(posedge KCLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
            FRAME_ERR   <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;
            if (state == ST_IDLE || fall) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            if (timed_out) begin
                state     <= ST_IDLE;
                FRAME_ERR <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= {data_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_bit <= data_sync;
                        state      <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (!push_good) begin
                            FRAME_ERR <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (KCLK),
        .rst   (RST),
        .push  (push_good),
        .din   (shift_reg),
        .pop   (pop_req),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pops are spaced by at least one idle cycle so KCOME never stays high.
    assign pop_req = !fifo_empty && !KCOME;

    always_ff @(posedge KCLK) begin
        if (RST) begin
            KCODE    <= 8'h00;
            KCOME    <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            KCOME    <= pop_req;
            OVERFLOW <= push_good && fifo_full && !pop_req;
            if (pop_req) begin
                KCODE <= fifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: bit-banged PS/2 frames, glitches, timeout,
// overflow and mid-frame reset, with hand-computed expected scan codes.
module tb_ps2_receiver;
    import ps2_receiver_pkg::*;

    localparam int TIMEOUT = 500;
    localparam int HALF    = 8;

    logic       kclk     = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kcode;
    logic       kcome, frame_err, overflow;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int fe_cnt      = 0;
    int fe_cyc      = -1;
    int ov_cnt      = 0;
    int last_fall_cyc = 0;
    logic [7:0] kq[$];
    int         kt[$];

    ps2_receiver #(
        .FILTER_LEN (4),
        .TIMEOUT    (TIMEOUT),
        .FIFO_DEPTH (4)
    ) dut (
        .KCLK      (kclk),
        .RST       (rst),
        .PS2_CLK   (ps2_clk),
        .PS2_DATA  (ps2_data),
        .KCODE     (kcode),
        .KCOME     (kcome),
        .FRAME_ERR (frame_err),
        .OVERFLOW  (overflow)
    );

    always #5 kclk = ~kclk;

    always @(posedge kclk) cyc++;

    // Output log sampled on the negedge, tagged with the posedge count.
    always @(negedge kclk) begin
        if (kcome) begin
            kq.push_back(kcode);
            kt.push_back(cyc);
        end
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (overflow) ov_cnt++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge kclk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge kclk);
        ps2_data = b;
        wait_cycles(HALF);
        ps2_clk       = 1'b0;
        last_fall_cyc = cyc;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(parity);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cycles(HALF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        vectors++;
        if (kcode !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_kcode: got %h expected 00", kcode);
        end
        vectors++;
        if ({kcome, frame_err, overflow} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: got %b expected 000", {kcome, frame_err, overflow});
        end
        rst = 1'b0;
        wait_cycles(10);
    endtask

    task automatic test_single_frame();
        int fe0;
        kq.delete(); kt.delete();
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0);
        wait_cycles(20);
        vectors++;
        if (kq.size() != 1 || kq[0] !== 8'h1C) begin
            miscompares++;
            $display("[TB] FAIL single_code: got %0d strobes first %h expected 1 strobe 1c",
                     kq.size(), (kq.size() > 0) ? kq[0] : 8'hxx);
        end
        vectors++;
        if (kt.size() < 1 || kt[0] != last_fall_cyc + 7) begin
            miscompares++;
            $display("[TB] FAIL single_latency: got cycle %0d expected %0d",
                     (kt.size() > 0) ? kt[0] : -1, last_fall_cyc + 7);
        end
        vectors++;
        if (kcode !== 8'h1C || fe_cnt != fe0) begin
            miscompares++;
            $display("[TB] FAIL single_hold: got kcode %h errs %0d expected 1c errs 0", kcode, fe_cnt - fe0);
        end
    endtask

    task automatic test_back_to_back();
        kq.delete(); kt.delete();
        force dut.pop_req = 1'b0;
        send_frame(BREAK_PREFIX, 1'b1);
        send_frame(8'h1C, 1'b0);
        wait_cycles(5);
        vectors++;
        if (kq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_stalled: got %0d strobes expected 0", kq.size());
        end
        release dut.pop_req;
        wait_cycles(10);
        vectors++;
        if (kq.size() != 2 || kq[0] !== 8'hF0 || kq[1] !== 8'h1C) begin
            miscompares++;
            $display("[TB] FAIL b2b_order: got %0d strobes %h %h expected f0 1c", kq.size(),
                     (kq.size() > 0) ? kq[0] : 8'hxx, (kq.size() > 1) ? kq[1] : 8'hxx);
        end
        vectors++;
        if (kt.size() != 2 || kt[1] - kt[0] != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles expected 2",
                     (kt.size() > 1) ? kt[1] - kt[0] : -1);
        end
    endtask

    task automatic test_parity_error();
        int fe0;
        kq.delete(); kt.delete();
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1);
        wait_cycles(10);
        vectors++;
        if (fe_cnt != fe0 + 1 || kq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL parity_err: got errs %0d strobes %0d expected errs 1 strobes 0",
                     fe_cnt - fe0, kq.size());
        end
        send_frame(8'h32, 1'b0);
        wait_cycles(10);
        vectors++;
        if (kq.size() != 1 || kq[0] !== 8'h32 || fe_cnt != fe0 + 1) begin
            miscompares++;
            $display("[TB] FAIL parity_recover: got %0d strobes first %h errs %0d expected 1 strobe 32 errs 1",
                     kq.size(), (kq.size() > 0) ? kq[0] : 8'hxx, fe_cnt - fe0);
        end
    endtask

    task automatic glitch(input int low_cycles);
        @(negedge kclk);
        ps2_clk = 1'b0;
        wait_cycles(low_cycles);
        ps2_clk = 1'b1;
        wait_cycles(12);
    endtask

    // An idle-line FALL with data high is a bad start bit, so each real FALL shows as FRAME_ERR.
    task automatic test_glitch();
        int fe0;
        int drive_cyc;
        kq.delete(); kt.delete();
        fe0 = fe_cnt;
        glitch(1);
        glitch(3);
        vectors++;
        if (fe_cnt != fe0) begin
            miscompares++;
            $display("[TB] FAIL glitch_short: got %0d falls expected 0", fe_cnt - fe0);
        end
        @(negedge kclk);
        ps2_clk   = 1'b0;
        drive_cyc = cyc;
        wait_cycles(4);
        ps2_clk = 1'b1;
        wait_cycles(20);
        vectors++;
        if (fe_cnt != fe0 + 1 || fe_cyc != drive_cyc + 6) begin
            miscompares++;
            $display("[TB] FAIL glitch_four: got %0d falls at cycle %0d expected 1 at %0d",
                     fe_cnt - fe0, fe_cyc, drive_cyc + 6);
        end
        vectors++;
        if (kq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_nodata: got %0d strobes expected 0", kq.size());
        end
    endtask

    task automatic test_timeout();
        int   target;
        logic early;
        logic [7:0] partial;
        kq.delete(); kt.delete();
        partial = 8'h15;
        early   = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(partial[i]);
        target = last_fall_cyc + 6 + TIMEOUT;
        while (cyc < target) begin
            @(negedge kclk);
            if (cyc < target && frame_err) early = 1'b1;
        end
        vectors++;
        if (frame_err !== 1'b1 || early !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_err: got err %b early %b at cycle %0d expected err 1 early 0",
                     frame_err, early, cyc);
        end
        wait_cycles(20);
        send_frame(8'h2A, 1'b0);
        wait_cycles(10);
        vectors++;
        if (kq.size() != 1 || kq[0] !== 8'h2A) begin
            miscompares++;
            $display("[TB] FAIL timeout_recover: got %0d strobes first %h expected 1 strobe 2a",
                     kq.size(), (kq.size() > 0) ? kq[0] : 8'hxx);
        end
    endtask

    task automatic test_overflow_reset();
        int ov0;
        kq.delete(); kt.delete();
        ov0 = ov_cnt;
        force dut.pop_req = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        wait_cycles(5);
        vectors++;
        if (ov_cnt != ov0) begin
            miscompares++;
            $display("[TB] FAIL ovf_early: got %0d overflows expected 0", ov_cnt - ov0);
        end
        send_frame(8'h55, 1'b1);
        wait_cycles(5);
        vectors++;
        if (ov_cnt != ov0 + 1 || kq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL ovf_fifth: got %0d overflows %0d strobes expected 1 overflow 0 strobes",
                     ov_cnt - ov0, kq.size());
        end
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge kclk);
        rst      = 1'b1;
        ps2_data = 1'b1;
        ps2_clk  = 1'b1;
        wait_cycles(1);
        vectors++;
        if (kcome !== 1'b0 || kcode !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL rst_outputs: got kcome %b kcode %h expected 0 00", kcome, kcode);
        end
        wait_cycles(2);
        release dut.pop_req;
        rst = 1'b0;
        wait_cycles(40);
        vectors++;
        if (kq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL rst_flush: got %0d strobes after reset expected 0", kq.size());
        end
        send_frame(8'h45, 1'b0);
        wait_cycles(10);
        vectors++;
        if (kq.size() != 1 || kq[0] !== 8'h45) begin
            miscompares++;
            $display("[TB] FAIL rst_recover: got %0d strobes first %h expected 1 strobe 45",
                     kq.size(), (kq.size() > 0) ? kq[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity_error();
        test_glitch();
        test_timeout();
        test_overflow_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Receives PS/2 keyboard frames from the PS2_CLK/PS2_DATA pins and delivers each scan-code byte as KCODE with a one-cycle KCOME strobe to the scan-code-to-ASCII stage directly downstream. It synchronizes and de-glitches the pins, checks start, odd-parity and stop bits, and aborts stalled frames by timeout. A small FIFO absorbs bursts such as the F0-prefixed break sequences.

## Interface
- FILTER_LEN, 4: consecutive equal synchronized samples required before the filtered PS2_CLK changes.
- TIMEOUT, 50000: cycles without a falling edge before a partial frame is aborted (1 ms at 50 MHz).
- FIFO_DEPTH, 4: scan-code buffer entries; power of two.
- KCLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  raw PS/2 clock pin; asynchronous.
- PS2_DATA  in  1  raw PS/2 data pin; asynchronous.
- KCODE  out  8  scan code; valid while KCOME=1 and held otherwise.
- KCOME  out  1  one-cycle strobe, one per received byte.
- FRAME_ERR  out  1  one-cycle pulse for a bad start/parity/stop bit or a timeout.
- OVERFLOW  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- Synchronizer: two flops per pin, reset to 1.
- Filter: the filtered clock starts at 1. It flips only after FILTER_LEN consecutive synchronized samples opposite to its current value. FALL is a one-cycle strobe on a filtered 1->0 transition.
- Data is sampled from the synchronized PS2_DATA in the FALL cycle.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE: on FALL with data=0, go to DATA and clear the bit counter. On FALL with data=1, stay in IDLE and pulse FRAME_ERR.
  - DATA: on each FALL, shift the bit in LSB-first (new bit into bit 7, shift right). After the 8th bit, go to PARITY.
  - PARITY: on FALL, store the bit and go to STOP.
  - STOP: on FALL, check that stop=1 and that the 8 data bits plus parity have an odd number of ones. If both hold, push the byte; otherwise pulse FRAME_ERR. Return to IDLE in either case.
- Timeout: the counter runs in every state except IDLE and clears on each FALL. When it reaches TIMEOUT-1, go to IDLE, pulse FRAME_ERR, and push nothing.
- FIFO write: on a good push with the FIFO full and no pop in the same cycle, drop the byte and pulse OVERFLOW. With a pop in the same cycle, the push is accepted.
- FIFO read: if the FIFO is not empty and KCOME was 0 in the previous cycle, pop the head to KCODE with KCOME=1. KCOME is therefore never high in two consecutive cycles.
- Reset values:
  - Outputs: KCODE=8'h00; KCOME, FRAME_ERR and OVERFLOW all 0.
  - Internal: FSM in IDLE, FIFO empty, counters 0.
- Reset mid-frame discards the partial byte and everything in the FIFO.

## Timing
- Pin-to-FALL: 2 synchronizer cycles plus FILTER_LEN filter cycles after the pin edge.
- Write-to-strobe: a byte pushed at edge N into an empty FIFO gives KCOME=1 after edge N+1, for one cycle. Queued bytes follow every 2 cycles.
- KCODE and KCOME change only on posedge, so they are stable at the consumer's negedge sampling.
- FRAME_ERR and OVERFLOW are asserted in the cycle after the triggering edge/timeout, for one cycle.
- Bit counter is 4 bits and saturates meaningfully at 8. Timeout counter is $clog2(TIMEOUT) bits. FIFO pointers are log2(FIFO_DEPTH)+1 bits, with full/empty from MSB comparison.

## Structure
- Add to define_constants.v: PS2 frame length (11), break prefix 8'hF0, and the FSM state encodings (2-bit).
- Sub-module ps2_fifo: byte-wide synchronous FIFO with sync active-high reset, push/pop/full/empty, and push-on-full ignored unless a pop occurs in the same cycle.
- Top level holds the synchronizer, filter, FSM, timeout counter and output pacing.

## Test plan
- Frame for 8'h1C (start 0, data LSB-first, parity 0, stop 1) -> one KCOME pulse with KCODE=8'h1C, no FRAME_ERR.
- Frames F0 then 1C back-to-back -> KCOME pulses with KCODE=8'hF0 then 8'h1C, exactly 2 cycles apart, in order.
- Frame 8'h1C with parity bit 1 -> FRAME_ERR pulse, no KCOME; the next valid frame 8'h32 is delivered normally.
- 1-cycle and 3-cycle low glitches on PS2_CLK with FILTER_LEN=4 -> no FALL, FSM stays IDLE, no outputs; a 4-cycle low produces one FALL.
- 5 data bits, then silence for TIMEOUT cycles -> FRAME_ERR after TIMEOUT cycles; a subsequent full frame for 8'h2A gives KCODE=8'h2A.
- Five good frames while the consumer path is forced to stall pops (FIFO_DEPTH=4), then RST asserted mid-sixth-frame -> OVERFLOW on the 5th frame; after RST, KCOME=0 and KCODE=8'h00, the FIFO is empty, and nothing is emitted until a new full frame arrives.
